// File: rtl/booth_radix4_seq_multiplier_pkg.sv
// rtl/booth_radix4_seq_multiplier_pkg.sv - shared types for the radix-4 Booth multiplier
//
// Purpose: FSM state encoding, Booth digit encoding and the triplet decoder
//          shared by the multiplier top and its digit-select sub-module.
// Ports:   none (package).
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_N1   = 3'd3,
    DIG_N2   = 3'd4
  } digit_e;

  // Bit-pair recoding of {B[2i+1], B[2i], B[2i-1]} into one digit in -2..+2.
  function automatic digit_e booth_decode(input logic [2:0] triplet);
    digit_e dig;
    case (triplet)
      3'b001, 3'b010: dig = DIG_P1;
      3'b011:         dig = DIG_P2;
      3'b100:         dig = DIG_N2;
      3'b101, 3'b110: dig = DIG_N1;
      default:        dig = DIG_ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_radix4_seq_multiplier_if.sv
// rtl/booth_radix4_seq_multiplier_if.sv - operand/product handshake bundle
//
// Purpose: groups the input (operands) and output (product) valid/ready
//          channels of the multiplier.
// Ports:   in_valid/in_ready/is_signed/multiplicand/multiplier (operand side),
//          out_valid/out_ready/product (result side).
//          master = producer of operands / consumer of product; slave = multiplier.
interface booth_radix4_seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               is_signed;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, is_signed, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, is_signed, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth_radix4_seq_multiplier_digit.sv
// rtl/booth_radix4_seq_multiplier_digit.sv - Booth digit to signed multiple of A
//
// Purpose: combinational selection of 0, +A, +2A, -A or -2A for one digit.
// Ports:   triplet_i  - {B[2i+1], B[2i], B[2i-1]}
//          a_ext_i    - multiplicand extended to WIDTH+2 bits
//          multiple_o - selected (WIDTH+2)-bit two's-complement multiple
module booth_digit_select
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       triplet_i,
  input  logic [WIDTH+1:0] a_ext_i,
  output logic [WIDTH+1:0] multiple_o
);

  logic [WIDTH+1:0] a_x2;

  // The two extension bits guarantee 2A still fits in WIDTH+2 bits.
  assign a_x2 = {a_ext_i[WIDTH:0], 1'b0};

  always_comb begin
    multiple_o = '0;
    case (booth_decode(triplet_i))
      DIG_P1:  multiple_o = a_ext_i;
      DIG_P2:  multiple_o = a_x2;
      DIG_N1:  multiple_o = -a_ext_i;
      DIG_N2:  multiple_o = -a_x2;
      default: multiple_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_seq_multiplier.sv
// rtl/booth_radix4_seq_multiplier.sv - iterative radix-4 Booth multiplier, one digit per clock
//
// Purpose: signed/unsigned WIDTH x WIDTH -> 2*WIDTH multiply, WIDTH/2+1 cycles
//          per operation, valid/ready on both sides, back-to-back capable.
// Ports:   clk - rising-edge clock
//          clr - asynchronous active-low reset
//          bus - operand/product handshake (slave side)
module booth_radix4_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         clr,
  booth_radix4_seq_multiplier_if.slave bus
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(ITER - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH+1:0]     a_q, a_d;
  // B extended to WIDTH+2 bits with the implicit bit -1 appended at the bottom;
  // it shifts right by 2 each digit so the current triplet is always b_q[2:0].
  logic [WIDTH+2:0]     b_q, b_d;
  logic [2*WIDTH+3:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic                 in_ready;
  logic                 accept;
  logic                 ext_a, ext_b;
  logic [WIDTH+1:0]     multiple;
  logic [WIDTH+1:0]     sum_hi;
  logic [2*WIDTH+3:0]   acc_step;
  logic                 unused_acc_lsbs;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign ext_a    = bus.is_signed & bus.multiplicand[WIDTH-1];
  assign ext_b    = bus.is_signed & bus.multiplier[WIDTH-1];

  booth_digit_select #(.WIDTH(WIDTH)) u_digit (
    .triplet_i  (b_q[2:0]),
    .a_ext_i    (a_q),
    .multiple_o (multiple)
  );

  // Add into the upper half, then arithmetic shift right by one digit.
  assign sum_hi   = acc_q[2*WIDTH+3:WIDTH+2] + multiple;
  assign acc_step = {{2{sum_hi[WIDTH+1]}}, sum_hi, acc_q[WIDTH+1:2]};
  assign unused_acc_lsbs = ^acc_q[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;

    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        acc_d = acc_step;
        b_d   = {{2{b_q[WIDTH+2]}}, b_q[WIDTH+2:2]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_DIGIT) begin
          state_d = ST_DONE;
          prod_d  = acc_step[2*WIDTH-1:0];
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new accept overrides the DONE->IDLE exit, giving back-to-back issue.
    if (accept) begin
      a_d     = {{2{ext_a}}, bus.multiplicand};
      b_d     = {{2{ext_b}}, bus.multiplier, 1'b0};
      acc_d   = '0;
      cnt_d   = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.product   = prod_q;

endmodule

// File: tb/tb_booth_radix4_seq_multiplier.sv
// tb/tb_booth_radix4_seq_multiplier.sv - directed vector bench for the radix-4 Booth multiplier
module tb_booth_radix4_seq_multiplier;

  localparam int W   = 32;
  localparam int LAT = W / 2 + 1;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  booth_radix4_seq_multiplier_if #(.WIDTH(W)) bus ();

  booth_radix4_seq_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  vec_t vecs[12];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents operands for one edge, then scrambles them.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input string name);
    int g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check({name, " in_ready before accept"}, 64'(bus.in_ready), 64'd1);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.is_signed    = s;
    bus.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid     = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    bus.is_signed    = 1'($urandom_range(0, 1));
  endtask

  // Counts edges after the accepting edge until out_valid; optionally
  // wiggles in_valid/operands while the operation is running.
  task automatic wait_done(input string name, input bit toggle);
    int lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (toggle && lat < 12) begin
        bus.in_valid     = 1'($urandom_range(0, 1));
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        bus.is_signed    = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (toggle && !bus.out_valid)
        check({name, " in_ready low in RUN"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(LAT));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'd7,        32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[3]  = '{32'h8000_0000, 32'd1,        1'b1, 64'hFFFF_FFFF_8000_0000};
    vecs[4]  = '{32'd0,        32'h1234_5678, 1'b1, 64'h0};
    vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1};
    vecs[6]  = '{32'h8000_0000, 32'd2,        1'b0, 64'h1_0000_0000};
    vecs[7]  = '{32'hFFFF_FFFF, 32'd1,        1'b0, 64'h0000_0000_FFFF_FFFF};
    vecs[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001};
    vecs[9]  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001};
    vecs[10] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 64'h7FFF_FFFF_8000_0000};
    vecs[11] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};

    clr              = 1'b0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b1;
    bus.is_signed    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #2;
    check("reset in_ready",  64'(bus.in_ready),  64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset product",   bus.product,        64'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      accept_op(vecs[i].a, vecs[i].b, vecs[i].s, $sformatf("v%0d", i));
      wait_done($sformatf("v%0d", i), 1'b0);
      check($sformatf("v%0d product", i), bus.product, vecs[i].p);
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid after take", i), 64'(bus.out_valid), 64'd0);
      check($sformatf("v%0d in_ready idle", i),        64'(bus.in_ready),  64'd1);
    end

    // Backpressure, then back-to-back accept on the handover edge.
    bus.out_ready = 1'b0;
    accept_op(32'd5, 32'd6, 1'b1, "bp");
    wait_done("bp", 1'b0);
    check("bp product", bus.product, 64'd30);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d out_valid", c), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp hold%0d product", c),   bus.product,        64'd30);
      check($sformatf("bp hold%0d in_ready", c),  64'(bus.in_ready),  64'd0);
    end
    bus.out_ready    = 1'b1;
    bus.in_valid     = 1'b1;
    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd3;
    bus.is_signed    = 1'b1;
    #1;
    check("b2b in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid     = 1'b0;
    bus.multiplicand = 32'hDEAD_BEEF;
    check("b2b out_valid drops", 64'(bus.out_valid), 64'd0);
    check("b2b in_ready in RUN", 64'(bus.in_ready),  64'd0);
    wait_done("b2b", 1'b0);
    check("b2b product", bus.product, 64'd6);
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    accept_op(32'd100, 32'd100, 1'b1, "rst");
    repeat (8) begin
      @(posedge clk); #1;
    end
    clr = 1'b0;
    #1;
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst product",   bus.product,        64'd0);
    check("rst in_ready",  64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;
    clr = 1'b1;
    begin
      int seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (bus.out_valid) seen++;
      end
      check("rst no stale output", 64'(seen), 64'd0);
    end
    accept_op(32'd123, 32'hFFFF_FFFE, 1'b1, "post_rst");
    wait_done("post_rst", 1'b0);
    check("post_rst product", bus.product, 64'hFFFF_FFFF_FFFF_FF0A);
    @(posedge clk); #1;

    // in_valid and operands wiggling during RUN must not disturb the result.
    accept_op(32'h0000_1234, 32'h0000_0010, 1'b0, "tog");
    wait_done("tog", 1'b1);
    check("tog product", bus.product, 64'h0000_0000_0001_2340);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_radix4_seq_multiplier.md
Name: booth_radix4_seq_multiplier

Overview:
Iterative radix-4 (bit-pair) Booth multiplier for the datapath MUL path. It retires one Booth digit per clock, which trades latency for area against the combinational tree multiplier. It is generalised to any even operand width and supports both signed and unsigned modes. It uses a valid/ready handshake on input and output so the control unit can stall on it.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 4.
ITER, WIDTH/2+1, number of Booth digits (derived; not overridable).

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands this cycle
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
multiplicand  input  WIDTH  operand A
multiplier  input  WIDTH  operand B
out_valid  output  1  product valid
out_ready  input  1  consumer takes product
product  output  2*WIDTH  A*B, full width

Behaviour:
- Reset (clr=0, async): state IDLE; in_ready=1, out_valid=0, product=0; iteration counter=0; accumulator cleared. Reset mid-operation discards the operation with no output.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept occurs on any edge with in_valid && in_ready:
  - latch A extended to WIDTH+2 bits (sign-extended if is_signed, else zero-extended);
  - latch B extended to WIDTH+2 bits the same way, plus implicit bit -1 = 0;
  - clear accumulator and counter; go to RUN.
- RUN, each edge performs one digit:
  - examine triplet {B[2i+1], B[2i], B[2i-1]}: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A;
  - negation is two's complement of the (WIDTH+2)-bit extended multiple;
  - add the multiple to the upper WIDTH+2 bits of a (2*WIDTH+4)-bit accumulator, then arithmetic-shift the accumulator right by 2;
  - after digit ITER-1, go to DONE, load product = accumulator low 2*WIDTH bits, assert out_valid.
- Latency: out_valid rises exactly ITER edges after the accepting edge (17 at WIDTH=32).
- DONE:
  - product and out_valid hold stable while out_ready=0;
  - on out_ready=1 with no new accept: out_valid falls on that edge, state goes to IDLE;
  - if in_valid is also high on that edge, the next operation is accepted on the same edge (back-to-back, no bubble) and state goes to RUN.
- in_valid during RUN is ignored; in_ready=0. Operands need not be held after acceptance.
- Arithmetic: the result equals the exact mathematical product truncated to 2*WIDTH bits, which is never lossy. Unsigned mode extends with zeros, so the top digit is never negative.
- product changes only when entering DONE (or on reset); it is not a live view of the accumulator.

Decomposition:
- Shared package mul_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - Booth digit select encoding: DIG_ZERO, DIG_P1, DIG_P2, DIG_N1, DIG_N2.
- One sub-module, booth_digit_select:
  - combinational, parametrised by WIDTH;
  - takes the 3-bit triplet and the (WIDTH+2)-bit extended A;
  - returns the (WIDTH+2)-bit signed multiple.
- The top level holds the FSM, counter, operand registers, accumulator and adder.

Test Plan (WIDTH=32):
1. Signed, A=7, B=-3, out_ready=1 -> out_valid high exactly 17 edges after accept, product=0xFFFFFFFFFFFFFFEB, then IDLE.
2. Unsigned, A=B=0xFFFFFFFF -> product=0xFFFFFFFE00000001.
3. Signed extremes:
   - A=B=0x80000000 -> 0x4000000000000000;
   - A=0x80000000, B=1 -> 0xFFFFFFFF80000000;
   - A=0, B=0x12345678 -> 0.
4. Backpressure and back-to-back:
   - hold out_ready=0 for 5 cycles after done -> product and out_valid stable, in_ready=0;
   - then out_ready=1 with in_valid=1 (A=2, B=3) -> accepted same edge, next product=6 after 17 edges.
5. Reset mid-operation: drop clr for 1 cycle at digit 8 -> out_valid=0 and product=0 immediately; in_ready=1; a fresh operation afterwards computes correctly.
6. in_valid toggling with changing operands during RUN -> ignored; the result matches the operands latched at accept.
